// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler slice.
package mul_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  localparam int N_DEF    = 4;
  localparam int NREQ_DEF = 4;
  localparam int TMO_DEF  = 8;

  // Requester index width, never below one bit.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Request/response channels between the ALU issue logic and the scheduler.
interface mul_sched_if
  import mul_sched_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF
) ();

  localparam int IW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_q;
  logic [NREQ*N-1:0] req_m;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [2*N-1:0]    rsp_p;
  logic              rsp_err;

  modport master (
    output req_valid, req_q, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );

  modport slave (
    input  req_valid, req_q, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );

endinterface

// File: rtl/mul_sched_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int            raw;
  logic [IW-1:0] idx;

  // Wrap manually so non-power-of-two NREQ works too.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    raw       = 0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      raw = int'(ptr) + k;
      if (raw >= NREQ) raw = raw - NREQ;
      idx = IW'(raw);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Shares one sequential signed multiplier among NREQ requesters with
// round-robin arbitration, load/run sequencing and a run timeout.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mul_sched_if.slave     bus,
  output logic           busy,
  output logic           mul_rst_n,
  output logic [N-1:0]   mul_q,
  output logic [N-1:0]   mul_m,
  input  logic           mul_done,
  input  logic [2*N-1:0] mul_p
);

  localparam int IW = id_width(NREQ);
  localparam int CW = $clog2(TMO + 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   run_cnt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;
  logic            timeout;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign accept  = (state == IDLE) && grant_any;
  assign timeout = (run_cnt == CW'(TMO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Completion is checked before timeout so a late-but-valid done still wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (mul_done || timeout) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) ? grant : '0;
    bus.rsp_valid = (state == RESP);
    busy          = (state != IDLE);
  end

  // Operands stay put through RUN since the multiplier samples q late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      run_cnt     <= '0;
      mul_rst_n   <= 1'b0;
      mul_q       <= '0;
      mul_m       <= '0;
      bus.rsp_id  <= '0;
      bus.rsp_p   <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      mul_rst_n <= (state_nxt == RUN);
      if (accept) begin
        rr_ptr     <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        mul_q      <= bus.req_q[int'(grant_idx)*N +: N];
        mul_m      <= bus.req_m[int'(grant_idx)*N +: N];
        bus.rsp_id <= grant_idx;
      end
      case (state)
        LOAD: run_cnt <= '0;
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (mul_done) begin
            bus.rsp_p   <= mul_p;
            bus.rsp_err <= 1'b0;
          end else if (timeout) begin
            bus.rsp_p   <= '0;
            bus.rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
